// File: rtl/obj_motion_pos.sv
// rtl/obj_motion_pos.sv - per-object horizontal position register with HMOVE fine motion
module obj_motion_pos #(
    parameter int RESET_OFFSET = 4,
    parameter int HBLANK_POS   = 3,
    parameter int LINE_PIXELS  = 160
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic [7:0] pixelNum,
    input  logic       hblank,
    input  logic       res_stb,
    input  logic       hm_wr,
    input  logic [3:0] hm_data,
    input  logic       hmclr,
    input  logic       hmove_stb,
    output logic [7:0] objPos,
    output logic       moving
);

    typedef enum logic {IDLE, MOVE} state_t;

    state_t     state;
    logic [7:0] pos;
    logic [3:0] hm;
    logic [3:0] steps;
    logic       dir;

    logic [8:0] resSum;
    logic [8:0] resWrapped;
    logic [7:0] resPos;
    logic [3:0] hmMag;
    logic [7:0] stepPos;

    // Reset-strobe target: visible pixel plus object offset, folded back into the line.
    always_comb begin
        resSum     = {1'b0, pixelNum} + 9'(RESET_OFFSET);
        resWrapped = (resSum >= 9'(LINE_PIXELS)) ? resSum - 9'(LINE_PIXELS) : resSum;
        resPos     = hblank ? 8'(HBLANK_POS) : resWrapped[7:0];
    end

    // Magnitude of the signed motion value; -8 negates to 4'b1000, which reads as 8 unsigned.
    always_comb begin
        hmMag = hm[3] ? (~hm + 4'd1) : hm;
    end

    // One-pixel step in the latched direction with wrap at both line ends.
    always_comb begin
        if (dir) begin
            stepPos = (pos == 8'd0) ? 8'(LINE_PIXELS - 1) : pos - 8'd1;
        end else begin
            stepPos = (pos == 8'(LINE_PIXELS - 1)) ? 8'd0 : pos + 8'd1;
        end
    end

    // Motion register, position and step FSM; reset strobe beats hmove beats a pending step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            pos   <= 8'd0;
            hm    <= 4'd0;
            steps <= 4'd0;
            dir   <= 1'b0;
        end else if (ce) begin
            if (hm_wr) begin
                hm <= hm_data;
            end else if (hmclr) begin
                hm <= 4'd0;
            end

            if (res_stb) begin
                pos   <= resPos;
                steps <= 4'd0;
                state <= IDLE;
            end else if (hmove_stb) begin
                dir   <= ~hm[3];
                steps <= hmMag;
                state <= (hmMag != 4'd0) ? MOVE : IDLE;
            end else if (state == MOVE) begin
                pos   <= stepPos;
                steps <= steps - 4'd1;
                if (steps == 4'd1) begin
                    state <= IDLE;
                end
            end
        end
    end

    assign objPos = pos;
    assign moving = (state == MOVE);

endmodule

// File: tb/tb_obj_motion_pos.sv
// tb/tb_obj_motion_pos.sv - directed self-checking bench for obj_motion_pos
module tb_obj_motion_pos;

    logic       clk;
    logic       rst_n;
    logic       ce;
    logic [7:0] pixelNum;
    logic       hblank;
    logic       res_stb;
    logic       hm_wr;
    logic [3:0] hm_data;
    logic       hmclr;
    logic       hmove_stb;
    logic [7:0] objPos;
    logic       moving;

    int testCount = 0;
    int failCount = 0;

    obj_motion_pos dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .pixelNum(pixelNum), .hblank(hblank),
        .res_stb(res_stb), .hm_wr(hm_wr), .hm_data(hm_data), .hmclr(hmclr),
        .hmove_stb(hmove_stb), .objPos(objPos), .moving(moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Load a position through a visible-pixel reset strobe (offset 4).
    task automatic load_pos(input logic [7:0] pix);
        pixelNum = pix; hblank = 1'b0; res_stb = 1'b1;
        cyc();
        res_stb = 1'b0;
    endtask

    task automatic write_hm(input logic [3:0] v);
        hm_data = v; hm_wr = 1'b1;
        cyc();
        hm_wr = 1'b0;
    endtask

    task automatic test_reset();
        load_pos(8'd100);
        testCount++;
        if (objPos !== 8'd104) begin $display("FAIL pre_reset_pos got %0d want 104", objPos); failCount++; end
        write_hm(4'h3);
        hmove_stb = 1'b1; cyc(); hmove_stb = 1'b0;
        cyc();
        testCount++;
        if (objPos !== 8'd103 || moving !== 1'b1) begin
            $display("FAIL pre_reset_move got pos=%0d mv=%b want 103/1", objPos, moving); failCount++;
        end
        #3 rst_n = 1'b0;
        #1;
        testCount++;
        if (objPos !== 8'd0 || moving !== 1'b0) begin
            $display("FAIL async_reset got pos=%0d mv=%b want 0/0", objPos, moving); failCount++;
        end
        #2 rst_n = 1'b1;
        cyc();
        hmove_stb = 1'b1; cyc(); hmove_stb = 1'b0;
        testCount++;
        if (moving !== 1'b0) begin $display("FAIL hm_cleared_by_reset got mv=%b want 0", moving); failCount++; end
        hblank = 1'b1; pixelNum = 8'd77; res_stb = 1'b1; cyc(); res_stb = 1'b0; hblank = 1'b0;
        testCount++;
        if (objPos !== 8'd3) begin $display("FAIL hblank_load got %0d want 3", objPos); failCount++; end
    endtask

    task automatic test_visible_reset();
        logic [7:0] pix [4];
        logic [7:0] exp [4];
        pix = '{8'd100, 8'd158, 8'd155, 8'd156};
        exp = '{8'd104, 8'd2,   8'd159, 8'd0};
        for (int i = 0; i < 4; i++) begin
            load_pos(pix[i]);
            testCount++;
            if (objPos !== exp[i]) begin
                $display("FAIL visible_reset pix=%0d got %0d want %0d", pix[i], objPos, exp[i]); failCount++;
            end
        end
    endtask

    task automatic test_left_wrap();
        logic [7:0] exp [7];
        exp = '{8'd2, 8'd1, 8'd0, 8'd159, 8'd158, 8'd157, 8'd156};
        hblank = 1'b1; res_stb = 1'b1; cyc(); res_stb = 1'b0; hblank = 1'b0;
        write_hm(4'h7);
        hmove_stb = 1'b1; cyc(); hmove_stb = 1'b0;
        testCount++;
        if (objPos !== 8'd3 || moving !== 1'b1) begin
            $display("FAIL left_strobe got pos=%0d mv=%b want 3/1", objPos, moving); failCount++;
        end
        for (int i = 0; i < 7; i++) begin
            cyc();
            testCount++;
            if (objPos !== exp[i] || moving !== (i < 6)) begin
                $display("FAIL left_step%0d got pos=%0d mv=%b want %0d/%b", i, objPos, moving, exp[i], (i < 6));
                failCount++;
            end
        end
    endtask

    task automatic test_right_stall();
        load_pos(8'd155);
        write_hm(4'h8);
        hmove_stb = 1'b1; cyc(); hmove_stb = 1'b0;
        cyc(); cyc(); cyc();
        testCount++;
        if (objPos !== 8'd2) begin $display("FAIL right_3steps got %0d want 2", objPos); failCount++; end
        ce = 1'b0;
        cyc(); cyc(); cyc();
        testCount++;
        if (objPos !== 8'd2 || moving !== 1'b1) begin
            $display("FAIL ce_stall got pos=%0d mv=%b want 2/1", objPos, moving); failCount++;
        end
        ce = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        testCount++;
        if (objPos !== 8'd6 || moving !== 1'b1) begin
            $display("FAIL right_7steps got pos=%0d mv=%b want 6/1", objPos, moving); failCount++;
        end
        cyc();
        testCount++;
        if (objPos !== 8'd7 || moving !== 1'b0) begin
            $display("FAIL right_final got pos=%0d mv=%b want 7/0", objPos, moving); failCount++;
        end
    endtask

    task automatic test_priority();
        write_hm(4'h3);
        pixelNum = 8'd50; res_stb = 1'b1; hmove_stb = 1'b1;
        cyc();
        res_stb = 1'b0; hmove_stb = 1'b0;
        testCount++;
        if (objPos !== 8'd54 || moving !== 1'b0) begin
            $display("FAIL res_over_hmove got pos=%0d mv=%b want 54/0", objPos, moving); failCount++;
        end
        cyc();
        testCount++;
        if (objPos !== 8'd54 || moving !== 1'b0) begin
            $display("FAIL res_over_hmove_hold got pos=%0d mv=%b want 54/0", objPos, moving); failCount++;
        end
        load_pos(8'd6);
        hm_data = 4'h2; hm_wr = 1'b1; hmclr = 1'b1; cyc(); hm_wr = 1'b0; hmclr = 1'b0;
        hmove_stb = 1'b1; cyc(); hmove_stb = 1'b0;
        cyc(); cyc();
        testCount++;
        if (objPos !== 8'd8 || moving !== 1'b0) begin
            $display("FAIL wr_over_clr got pos=%0d mv=%b want 8/0", objPos, moving); failCount++;
        end
        write_hm(4'h3);
        hmclr = 1'b1; cyc(); hmclr = 1'b0;
        hmove_stb = 1'b1; cyc(); hmove_stb = 1'b0;
        testCount++;
        if (objPos !== 8'd8 || moving !== 1'b0) begin
            $display("FAIL hmclr got pos=%0d mv=%b want 8/0", objPos, moving); failCount++;
        end
    endtask

    task automatic test_mid_motion();
        load_pos(8'd20);
        write_hm(4'h5);
        hmove_stb = 1'b1; cyc(); hmove_stb = 1'b0;
        hm_data = 4'hF; hm_wr = 1'b1; cyc(); hm_wr = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        testCount++;
        if (objPos !== 8'd19 || moving !== 1'b0) begin
            $display("FAIL hm_wr_in_flight got pos=%0d mv=%b want 19/0", objPos, moving); failCount++;
        end
        write_hm(4'h5);
        hmove_stb = 1'b1; cyc(); hmove_stb = 1'b0;
        cyc();
        pixelNum = 8'd70; res_stb = 1'b1; cyc(); res_stb = 1'b0;
        testCount++;
        if (objPos !== 8'd74 || moving !== 1'b0) begin
            $display("FAIL res_cancels_move got pos=%0d mv=%b want 74/0", objPos, moving); failCount++;
        end
        write_hm(4'hE);
        hmove_stb = 1'b1; cyc(); hmove_stb = 1'b0;
        cyc();
        hmove_stb = 1'b1; cyc(); hmove_stb = 1'b0;
        testCount++;
        if (objPos !== 8'd75 || moving !== 1'b1) begin
            $display("FAIL hmove_restart got pos=%0d mv=%b want 75/1", objPos, moving); failCount++;
        end
        cyc(); cyc();
        testCount++;
        if (objPos !== 8'd77 || moving !== 1'b0) begin
            $display("FAIL hmove_restart_end got pos=%0d mv=%b want 77/0", objPos, moving); failCount++;
        end
    endtask

    initial begin
        rst_n = 1'b0; ce = 1'b1; pixelNum = 8'd0; hblank = 1'b0; res_stb = 1'b0;
        hm_wr = 1'b0; hm_data = 4'd0; hmclr = 1'b0; hmove_stb = 1'b0;
        #12;
        testCount++;
        if (objPos !== 8'd0 || moving !== 1'b0) begin
            $display("FAIL initial_reset got pos=%0d mv=%b want 0/0", objPos, moving); failCount++;
        end
        #5 rst_n = 1'b1;
        cyc();
        test_reset();
        test_visible_reset();
        test_left_wrap();
        test_right_stall();
        test_priority();
        test_mid_motion();
        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
